// File: rtl/patgen_if.sv
// Video timing bundle between the upstream sync generator, patgen and the display sink.
// Sync inputs are active-low; DSP_DE qualifies DSP_R/G/B, which are zero whenever DSP_DE is low.
interface patgen_if #(
    parameter int BPC = 8
);
    logic           DSP_HSYNC_IN_X;
    logic           DSP_VSYNC_IN_X;
    logic           DSP_preDE;
    logic           DSP_HSYNC_X;
    logic           DSP_VSYNC_X;
    logic           DSP_DE;
    logic [BPC-1:0] DSP_R;
    logic [BPC-1:0] DSP_G;
    logic [BPC-1:0] DSP_B;

    // patgen side
    modport slave (
        input  DSP_HSYNC_IN_X,
        input  DSP_VSYNC_IN_X,
        input  DSP_preDE,
        output DSP_HSYNC_X,
        output DSP_VSYNC_X,
        output DSP_DE,
        output DSP_R,
        output DSP_G,
        output DSP_B
    );

    // sync generator / sink side
    modport master (
        output DSP_HSYNC_IN_X,
        output DSP_VSYNC_IN_X,
        output DSP_preDE,
        input  DSP_HSYNC_X,
        input  DSP_VSYNC_X,
        input  DSP_DE,
        input  DSP_R,
        input  DSP_G,
        input  DSP_B
    );
endinterface

// File: rtl/patgen.sv
// Test pattern generator: colour bars, gray ramp, grid and checkerboard aligned to upstream sync.
// Optional macro PATGEN_SCROLL_EN adds a per-frame horizontal scroll to patterns 1-3.
module patgen #(
    parameter int BPC = 8
) (
    input  logic       DCLK,
    input  logic       DRST,
    input  logic [1:0] RESOL,
    input  logic [1:0] PATSEL,
    patgen_if.slave    vid
);

    logic           hsync_q;
    logic           vsync_q;
    logic           de_q;
    logic [BPC-1:0] r_q;
    logic [BPC-1:0] g_q;
    logic [BPC-1:0] b_q;

    logic           prede_d;
    logic           vsync_d;
    logic           vs_fall;
    logic           pde_fall;

    logic [10:0]    hpos;
    logic [10:0]    vpos;
    logic [10:0]    xpos;
    logic [1:0]     pat_q;

    logic [7:0]     bar_cnt;
    logic [7:0]     bar_w;
    logic [7:0]     bar_w_sel;
    logic [2:0]     bar_idx;
    logic [2:0]     bar_rgb;

    logic           grid_on;
    logic           check_on;
    logic [BPC-1:0] pix_r;
    logic [BPC-1:0] pix_g;
    logic [BPC-1:0] pix_b;

    // Edge history resets low so no spurious edge is seen on the first cycle after reset.
    assign vs_fall  = vsync_d & ~vid.DSP_VSYNC_IN_X;
    assign pde_fall = prede_d & ~vid.DSP_preDE;

`ifdef PATGEN_SCROLL_EN
    logic [7:0] frame_cnt;

    always_ff @(posedge DCLK) begin
        if (DRST) begin
            frame_cnt <= 8'd0;
        end else if (vs_fall) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign xpos = hpos + {3'd0, frame_cnt};
`else
    assign xpos = hpos;
`endif

    always_comb begin
        bar_w_sel = 8'd80;
        unique case (RESOL)
            2'd0:    bar_w_sel = 8'd80;
            2'd1:    bar_w_sel = 8'd100;
            2'd2:    bar_w_sel = 8'd128;
            default: bar_w_sel = 8'd160;
        endcase
    end

    // {R,G,B} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black.
    always_comb begin
        bar_rgb = 3'b000;
        unique case (bar_idx)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
    end

    assign grid_on  = (xpos[4:0] == 5'd0) || (vpos[4:0] == 5'd0);
    assign check_on = xpos[5] ^ vpos[5];

    always_comb begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        unique case (pat_q)
            2'd0: begin
                pix_r = {BPC{bar_rgb[2]}};
                pix_g = {BPC{bar_rgb[1]}};
                pix_b = {BPC{bar_rgb[0]}};
            end
            2'd1: begin
                pix_r = BPC'(xpos[9:2]);
                pix_g = BPC'(xpos[9:2]);
                pix_b = BPC'(xpos[9:2]);
            end
            2'd2: begin
                pix_r = {BPC{grid_on}};
                pix_g = {BPC{grid_on}};
                pix_b = {BPC{grid_on}};
            end
            default: begin
                pix_r = {BPC{check_on}};
                pix_g = {BPC{check_on}};
                pix_b = {BPC{check_on}};
            end
        endcase
    end

    always_ff @(posedge DCLK) begin
        if (DRST) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            prede_d <= 1'b0;
            vsync_d <= 1'b0;
        end else begin
            hsync_q <= vid.DSP_HSYNC_IN_X;
            vsync_q <= vid.DSP_VSYNC_IN_X;
            de_q    <= vid.DSP_preDE;
            prede_d <= vid.DSP_preDE;
            vsync_d <= vid.DSP_VSYNC_IN_X;
            if (vid.DSP_preDE) begin
                r_q <= pix_r;
                g_q <= pix_g;
                b_q <= pix_b;
            end else begin
                r_q <= '0;
                g_q <= '0;
                b_q <= '0;
            end
        end
    end

    // Vertical sync restarts the line count even if a line ends in the same cycle.
    always_ff @(posedge DCLK) begin
        if (DRST) begin
            hpos  <= 11'd0;
            vpos  <= 11'd0;
            pat_q <= 2'd0;
        end else begin
            hpos <= vid.DSP_preDE ? hpos + 11'd1 : 11'd0;
            if (vs_fall) begin
                vpos  <= 11'd0;
                pat_q <= PATSEL;
            end else if (pde_fall) begin
                vpos <= vpos + 11'd1;
            end
        end
    end

    // Bar width is captured during blanking, so a RESOL change lands on the next line.
    always_ff @(posedge DCLK) begin
        if (DRST) begin
            bar_cnt <= 8'd0;
            bar_idx <= 3'd0;
            bar_w   <= 8'd80;
        end else if (!vid.DSP_preDE) begin
            bar_cnt <= 8'd0;
            bar_idx <= 3'd0;
            bar_w   <= bar_w_sel;
        end else if (bar_cnt == bar_w - 8'd1) begin
            bar_cnt <= 8'd0;
            if (bar_idx != 3'd7) begin
                bar_idx <= bar_idx + 3'd1;
            end
        end else begin
            bar_cnt <= bar_cnt + 8'd1;
        end
    end

    assign vid.DSP_HSYNC_X = hsync_q;
    assign vid.DSP_VSYNC_X = vsync_q;
    assign vid.DSP_DE      = de_q;
    assign vid.DSP_R       = r_q;
    assign vid.DSP_G       = g_q;
    assign vid.DSP_B       = b_q;

endmodule
